alu_share_ctrl: RTL and testbench

Two-port scheduler that time-shares the single combinational 32-bit ALU between two requesters (e.g. integer pipe and address/branch unit). Each requester issues an operation over a valid/ready request channel and receives the result and the five ALU flags on its own valid/ready response channel. The block arbitrates round-robin, registers operands into the ALU, captures its outputs, screens illegal opcodes and holds each response until it is taken.

---
 rtl/alu_share_ctrl.sv | 167 ++++++++++++++++
 tb/tb_alu_share_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
// Round-robin scheduler sharing one combinational 32-bit ALU between two requesters.
// Operands are registered into the ALU, results captured one cycle later and held until taken.
module alu_share_ctrl #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid0,
    input  logic         req_valid1,
    output logic         req_ready0,
    output logic         req_ready1,
    input  logic [5:0]   req_aluc0,
    input  logic [5:0]   req_aluc1,
    input  logic [W-1:0] req_a0,
    input  logic [W-1:0] req_a1,
    input  logic [W-1:0] req_b0,
    input  logic [W-1:0] req_b1,
    output logic         resp_valid0,
    output logic         resp_valid1,
    input  logic         resp_ready0,
    input  logic         resp_ready1,
    output logic [W-1:0] resp_r,
    output logic [4:0]   resp_flags,
    output logic         resp_err,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [5:0]   alu_aluc,
    input  logic [W-1:0] alu_r,
    input  logic         alu_zero,
    input  logic         alu_carry,
    input  logic         alu_negative,
    input  logic         alu_overflow,
    input  logic         alu_flag
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic         last_grant_q, last_grant_d;
    logic         owner_q, owner_d;
    logic [5:0]   op_aluc_q, op_aluc_d;
    logic [W-1:0] op_a_q, op_a_d;
    logic [W-1:0] op_b_q, op_b_d;
    logic [W-1:0] resp_r_q, resp_r_d;
    logic [4:0]   resp_flags_q, resp_flags_d;
    logic         resp_err_q, resp_err_d;
    logic         grant_s;
    logic         any_valid_s;
    logic         owner_ready_s;

    function automatic logic is_legal(input logic [5:0] aluc);
        logic ok;
        casez (aluc)
            6'b100???: ok = 1'b1;
            6'b101010, 6'b101011: ok = 1'b1;
            6'b000000, 6'b000010, 6'b000011, 6'b000100,
            6'b000110, 6'b000111, 6'b001111: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Arbitration: on a tie the requester that did not win last time is chosen.
    always_comb begin
        any_valid_s = req_valid0 | req_valid1;
        grant_s     = 1'b0;
        if (req_valid0 && req_valid1) begin
            grant_s = ~last_grant_q;
        end else if (req_valid1) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
        req_ready0    = (state_q == IDLE) && any_valid_s && !grant_s;
        req_ready1    = (state_q == IDLE) && any_valid_s && grant_s;
        owner_ready_s = owner_q ? resp_ready1 : resp_ready0;
    end

    // Next-state and datapath update for the IDLE/EXEC/RESP sequence.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        op_aluc_d    = op_aluc_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        resp_r_d     = resp_r_q;
        resp_flags_d = resp_flags_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            IDLE: begin
                if (any_valid_s) begin
                    state_d   = EXEC;
                    owner_d   = grant_s;
                    op_aluc_d = grant_s ? req_aluc1 : req_aluc0;
                    op_a_d    = grant_s ? req_a1 : req_a0;
                    op_b_d    = grant_s ? req_b1 : req_b0;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                state_d = RESP;
                // Illegal opcodes never expose whatever the ALU produced.
                if (is_legal(op_aluc_q)) begin
                    resp_r_d     = alu_r;
                    resp_flags_d = {alu_zero, alu_carry, alu_negative, alu_overflow, alu_flag};
                    resp_err_d   = 1'b0;
                end else begin
                    resp_r_d     = {W{1'b0}};
                    resp_flags_d = 5'b00000;
                    resp_err_d   = 1'b1;
                end
            end
            RESP: begin
                if (owner_ready_s) begin
                    last_grant_d = owner_q;
                    state_d      = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, operand and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            op_aluc_q    <= 6'b000000;
            op_a_q       <= {W{1'b0}};
            op_b_q       <= {W{1'b0}};
            resp_r_q     <= {W{1'b0}};
            resp_flags_q <= 5'b00000;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            op_aluc_q    <= op_aluc_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            resp_r_q     <= resp_r_d;
            resp_flags_q <= resp_flags_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign alu_a       = op_a_q;
    assign alu_b       = op_b_q;
    assign alu_aluc    = op_aluc_q;
    assign resp_r      = resp_r_q;
    assign resp_flags  = resp_flags_q;
    assign resp_err    = resp_err_q;
    assign resp_valid0 = (state_q == RESP) && !owner_q;
    assign resp_valid1 = (state_q == RESP) && owner_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a small behavioural ALU supplying results.
module tb_alu_share_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid0, req_valid1, req_ready0, req_ready1;
    logic [5:0]  req_aluc0, req_aluc1;
    logic [31:0] req_a0, req_a1, req_b0, req_b1;
    logic        resp_valid0, resp_valid1, resp_ready0, resp_ready1;
    logic [31:0] resp_r;
    logic [4:0]  resp_flags;
    logic        resp_err;
    logic [31:0] alu_a, alu_b, alu_r;
    logic [5:0]  alu_aluc;
    logic        alu_zero, alu_carry, alu_negative, alu_overflow, alu_flag;
    int          checks = 0;
    int          failures = 0;

    alu_share_ctrl #(.W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid0(req_valid0), .req_valid1(req_valid1),
        .req_ready0(req_ready0), .req_ready1(req_ready1),
        .req_aluc0(req_aluc0), .req_aluc1(req_aluc1),
        .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
        .resp_valid0(resp_valid0), .resp_valid1(resp_valid1),
        .resp_ready0(resp_ready0), .resp_ready1(resp_ready1),
        .resp_r(resp_r), .resp_flags(resp_flags), .resp_err(resp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc), .alu_r(alu_r),
        .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_negative(alu_negative),
        .alu_overflow(alu_overflow), .alu_flag(alu_flag)
    );

    always #5 clk = ~clk;

    // Reference ALU for the opcodes exercised; unknown opcodes produce junk to prove masking.
    always_comb begin
        logic [32:0] sum;
        sum          = 33'd0;
        alu_r        = 32'hDEADBEEF;
        alu_carry    = 1'b1;
        alu_overflow = 1'b1;
        alu_flag     = 1'b1;
        case (alu_aluc)
            6'b100000: begin
                sum          = {1'b0, alu_a} + {1'b0, alu_b};
                alu_r        = sum[31:0];
                alu_carry    = sum[32];
                alu_overflow = (alu_a[31] == alu_b[31]) && (alu_r[31] != alu_a[31]);
                alu_flag     = 1'b0;
            end
            6'b100010: begin
                alu_r        = alu_a - alu_b;
                alu_carry    = alu_a < alu_b;
                alu_overflow = (alu_a[31] != alu_b[31]) && (alu_r[31] != alu_a[31]);
                alu_flag     = 1'b0;
            end
            6'b101010: begin
                alu_flag     = $signed(alu_a) < $signed(alu_b);
                alu_r        = {31'd0, alu_flag};
                alu_carry    = 1'b0;
                alu_overflow = 1'b0;
            end
            6'b001111: begin
                alu_r        = {alu_b[15:0], 16'h0000};
                alu_carry    = 1'b0;
                alu_overflow = 1'b0;
                alu_flag     = 1'b0;
            end
            default: begin
                alu_r = 32'hDEADBEEF;
            end
        endcase
        alu_zero     = (alu_aluc == 6'b111111) ? 1'b1 : (alu_r == 32'd0);
        alu_negative = alu_r[31];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid0 = 1'b0; req_valid1 = 1'b0; resp_ready0 = 1'b0; resp_ready1 = 1'b0;
        req_aluc0 = 6'd0; req_aluc1 = 6'd0;
        req_a0 = 32'd0; req_a1 = 32'd0; req_b0 = 32'd0; req_b1 = 32'd0;
        step();
        step();
        checks++;
        if ({resp_valid0, resp_valid1, req_ready0, req_ready1, resp_err} !== 5'b00000) begin
            failures++;
            $display("FAIL reset_ctrl actual=%b expected=00000",
                     {resp_valid0, resp_valid1, req_ready0, req_ready1, resp_err});
        end
        checks++;
        if ({alu_a, alu_b, alu_aluc, resp_r, resp_flags} !== 107'd0) begin
            failures++;
            $display("FAIL reset_data actual=%h/%h/%b/%h/%b expected=all zero",
                     alu_a, alu_b, alu_aluc, resp_r, resp_flags);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_contention();
        logic exp;
        req_valid0 = 1'b1; req_aluc0 = 6'b100010; req_a0 = 32'd5; req_b0 = 32'd3;
        req_valid1 = 1'b1; req_aluc1 = 6'b101010; req_a1 = 32'hFFFFFFFF; req_b1 = 32'd0;
        #1;
        for (int i = 0; i < 4; i++) begin
            exp = i[0];
            checks++;
            if ({req_ready0, req_ready1} !== {~exp, exp}) begin
                failures++;
                $display("FAIL cont_grant%0d actual=%b expected=%b", i, {req_ready0, req_ready1}, {~exp, exp});
            end
            step();
            if (i == 2) req_valid0 = 1'b0;
            if (i == 3) req_valid1 = 1'b0;
            checks++;
            if ({resp_valid0, resp_valid1, req_ready0, req_ready1} !== 4'b0000) begin
                failures++;
                $display("FAIL cont_exec%0d actual=%b expected=0000", i,
                         {resp_valid0, resp_valid1, req_ready0, req_ready1});
            end
            step();
            checks++;
            if ({resp_valid0, resp_valid1} !== {~exp, exp}) begin
                failures++;
                $display("FAIL cont_valid%0d actual=%b expected=%b", i, {resp_valid0, resp_valid1}, {~exp, exp});
            end
            checks++;
            if ({resp_r, resp_flags, resp_err} !== (exp ? {32'd1, 5'b00001, 1'b0} : {32'd2, 5'b00000, 1'b0})) begin
                failures++;
                $display("FAIL cont_result%0d actual=%h/%b/%b expected=%s", i, resp_r, resp_flags, resp_err,
                         exp ? "1/00001/0" : "2/00000/0");
            end
            if (exp) resp_ready1 = 1'b1; else resp_ready0 = 1'b1;
            step();
            resp_ready0 = 1'b0; resp_ready1 = 1'b0;
        end
    endtask

    task automatic test_single_op();
        req_valid0 = 1'b1; req_aluc0 = 6'b100000; req_a0 = 32'hFFFFFFFF; req_b0 = 32'd1;
        #1;
        checks++;
        if ({req_ready0, req_ready1} !== 2'b10) begin
            failures++;
            $display("FAIL single_ready actual=%b expected=10", {req_ready0, req_ready1});
        end
        step();
        req_valid0 = 1'b0;
        checks++;
        if (resp_valid0 !== 1'b0 || alu_a !== 32'hFFFFFFFF || alu_aluc !== 6'b100000) begin
            failures++;
            $display("FAIL single_exec actual=%b/%h/%b expected=0/ffffffff/100000", resp_valid0, alu_a, alu_aluc);
        end
        step();
        checks++;
        if ({resp_valid0, resp_valid1, resp_r, resp_flags, resp_err} !== {2'b10, 32'd0, 5'b11000, 1'b0}) begin
            failures++;
            $display("FAIL single_resp actual=%b%b/%h/%b/%b expected=10/00000000/11000/0",
                     resp_valid0, resp_valid1, resp_r, resp_flags, resp_err);
        end
        resp_ready0 = 1'b1;
        step();
        resp_ready0 = 1'b0;
        checks++;
        if (resp_valid0 !== 1'b0) begin
            failures++;
            $display("FAIL single_done actual=%b expected=0", resp_valid0);
        end
    endtask

    task automatic test_illegal();
        req_valid1 = 1'b1; req_aluc1 = 6'b111111; req_a1 = 32'h12345678; req_b1 = 32'h9;
        step();
        req_valid1 = 1'b0;
        step();
        checks++;
        if ({resp_valid0, resp_valid1, resp_r, resp_flags, resp_err} !== {2'b01, 32'd0, 5'b00000, 1'b1}) begin
            failures++;
            $display("FAIL illegal_resp actual=%b%b/%h/%b/%b expected=01/00000000/00000/1",
                     resp_valid0, resp_valid1, resp_r, resp_flags, resp_err);
        end
        resp_ready0 = 1'b1;
        step();
        resp_ready0 = 1'b0;
        checks++;
        if (resp_valid1 !== 1'b1) begin
            failures++;
            $display("FAIL illegal_nonowner_ready actual=%b expected=1", resp_valid1);
        end
        resp_ready1 = 1'b1;
        step();
        resp_ready1 = 1'b0;
        req_valid1 = 1'b1; req_aluc1 = 6'b100000; req_a1 = 32'd2; req_b1 = 32'd3;
        step();
        req_valid1 = 1'b0;
        step();
        checks++;
        if ({resp_valid1, resp_r, resp_err} !== {1'b1, 32'd5, 1'b0}) begin
            failures++;
            $display("FAIL illegal_clear actual=%b/%h/%b expected=1/00000005/0", resp_valid1, resp_r, resp_err);
        end
        resp_ready1 = 1'b1;
        step();
        resp_ready1 = 1'b0;
    endtask

    task automatic test_backpressure();
        req_valid0 = 1'b1; req_aluc0 = 6'b100000; req_a0 = 32'd7; req_b0 = 32'd8;
        req_valid1 = 1'b1; req_aluc1 = 6'b100010; req_a1 = 32'd10; req_b1 = 32'd4;
        #1;
        checks++;
        if ({req_ready0, req_ready1} !== 2'b10) begin
            failures++;
            $display("FAIL bp_grant0 actual=%b expected=10", {req_ready0, req_ready1});
        end
        step();
        req_valid0 = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({resp_valid0, req_ready1, resp_r, resp_flags} !== {2'b10, 32'd15, 5'b00000}) begin
                failures++;
                $display("FAIL bp_hold%0d actual=%b%b/%h/%b expected=10/0000000f/00000", i,
                         resp_valid0, req_ready1, resp_r, resp_flags);
            end
            step();
        end
        resp_ready0 = 1'b1;
        step();
        resp_ready0 = 1'b0;
        checks++;
        if ({resp_valid0, req_ready0, req_ready1} !== 3'b001) begin
            failures++;
            $display("FAIL bp_grant1 actual=%b expected=001", {resp_valid0, req_ready0, req_ready1});
        end
        step();
        req_valid1 = 1'b0;
        step();
        checks++;
        if ({resp_valid1, resp_r} !== {1'b1, 32'd6}) begin
            failures++;
            $display("FAIL bp_resp1 actual=%b/%h expected=1/00000006", resp_valid1, resp_r);
        end
        resp_ready1 = 1'b1;
        step();
        resp_ready1 = 1'b0;
    endtask

    task automatic test_reset_mid_exec();
        req_valid1 = 1'b1; req_aluc1 = 6'b100000; req_a1 = 32'h11; req_b1 = 32'h22;
        step();
        req_valid1 = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({alu_a, alu_b, alu_aluc, resp_r, resp_flags, resp_err, resp_valid0, resp_valid1} !== 110'd0) begin
            failures++;
            $display("FAIL rst_exec_outputs actual=%h/%h/%b/%h/%b/%b%b%b expected=all zero",
                     alu_a, alu_b, alu_aluc, resp_r, resp_flags, resp_err, resp_valid0, resp_valid1);
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({resp_valid0, resp_valid1} !== 2'b00) begin
                failures++;
                $display("FAIL rst_no_resp%0d actual=%b expected=00", i, {resp_valid0, resp_valid1});
            end
        end
        req_valid0 = 1'b1; req_valid1 = 1'b1;
        #1;
        checks++;
        if ({req_ready0, req_ready1} !== 2'b10) begin
            failures++;
            $display("FAIL rst_tie_grant actual=%b expected=10", {req_ready0, req_ready1});
        end
        req_valid0 = 1'b0; req_valid1 = 1'b0;
        step();
    endtask

    task automatic test_operand_isolation();
        req_valid0 = 1'b1; req_aluc0 = 6'b001111; req_a0 = 32'h0000AAAA; req_b0 = 32'h00001234;
        step();
        req_valid0 = 1'b0; req_a0 = 32'h55555555; req_b0 = 32'h0000FFFF;
        checks++;
        if ({alu_a, alu_b} !== {32'h0000AAAA, 32'h00001234}) begin
            failures++;
            $display("FAIL iso_operands actual=%h/%h expected=0000aaaa/00001234", alu_a, alu_b);
        end
        step();
        checks++;
        if ({resp_valid0, resp_r} !== {1'b1, 32'h12340000}) begin
            failures++;
            $display("FAIL iso_result actual=%b/%h expected=1/12340000", resp_valid0, resp_r);
        end
        resp_ready0 = 1'b1;
        step();
        resp_ready0 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single_op();
        test_illegal();
        test_backpressure();
        test_reset_mid_exec();
        test_operand_isolation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
